display_scan_mux: RTL

DISPLAY_SCAN_MUX -- requirements
Module: display_scan_mux

---
 rtl/display_scan_mux.sv | 125 ++++++++++++
 1 files changed

// File: rtl/display_scan_mux.sv
// Time-multiplexed scan of N_DIGITS segment patterns onto one shared segment bus.
// Each digit is lit for PRESCALE cycles, then all anodes are held dark for DEAD_CYCLES cycles.
module display_scan_mux #(
    parameter int N_DIGITS    = 4,
    parameter int SEG_W       = 8,
    parameter int PRESCALE    = 100000,
    parameter int DEAD_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      load,
    input  logic [N_DIGITS*SEG_W-1:0] digits_in,
    input  logic [N_DIGITS-1:0]       blank_mask,
    output logic [N_DIGITS-1:0]       an_n,
    output logic [SEG_W-1:0]          seg,
    output logic                      frame_tick
);

    localparam int IDX_W   = $clog2(N_DIGITS);
    localparam int CNT_MAX = (PRESCALE > DEAD_CYCLES) ? PRESCALE : DEAD_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        GAP
    } state_t;

    state_t                    state, state_nx;
    logic [IDX_W-1:0]          idx, idx_nx, idx_adv;
    logic [CNT_W-1:0]          cnt, cnt_nx;
    logic [N_DIGITS*SEG_W-1:0] shadow, shadow_nx;
    logic                      armed;
    logic                      wrap_nx;
    logic                      lit_nx;
    logic [N_DIGITS-1:0]       an_nx;
    logic [SEG_W-1:0]          seg_nx;

    // Outputs are derived from the post-edge state so they can be registered alongside it.
    always_comb begin
        shadow_nx = load ? digits_in : shadow;
        idx_adv   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        state_nx  = state;
        idx_nx    = idx;
        cnt_nx    = cnt;
        wrap_nx   = 1'b0;

        if (!en) begin
            state_nx = IDLE;
            idx_nx   = '0;
            cnt_nx   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (armed) begin
                        state_nx = SHOW;
                        idx_nx   = '0;
                        cnt_nx   = '0;
                    end
                end
                SHOW: begin
                    if (cnt == SHOW_LAST) begin
                        cnt_nx = '0;
                        if (DEAD_CYCLES > 0) begin
                            state_nx = GAP;
                        end else begin
                            idx_nx  = idx_adv;
                            wrap_nx = (idx == IDX_LAST);
                        end
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        state_nx = SHOW;
                        cnt_nx   = '0;
                        idx_nx   = idx_adv;
                        wrap_nx  = (idx == IDX_LAST);
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    idx_nx   = '0;
                    cnt_nx   = '0;
                end
            endcase
        end

        lit_nx = (state_nx == SHOW) && !blank_mask[idx_nx];
        an_nx  = lit_nx ? ~(N_DIGITS'(1) << idx_nx) : '1;
        seg_nx = lit_nx ? shadow_nx[idx_nx*SEG_W +: SEG_W] : '0;
    end

    // armed holds off the first SHOW until one full edge has passed after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            shadow     <= '0;
            armed      <= 1'b0;
            an_n       <= '1;
            seg        <= '0;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_nx;
            idx        <= idx_nx;
            cnt        <= cnt_nx;
            shadow     <= shadow_nx;
            armed      <= 1'b1;
            an_n       <= an_nx;
            seg        <= seg_nx;
            frame_tick <= wrap_nx;
        end
    end

endmodule
